multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 136 +++++++++++++
 tb/tb_multicycle_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: registered Moore control outputs,
// combinational PC enable and ALU-operation decode.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
      BEQEX   = 4'd8,  ADDIEX  = 4'd9,  JEX    = 4'd10, ADDIWB = 4'd11
   } state_t;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic       alusrca;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
   } ctrl_t;

   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                          OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

   function automatic state_t next_of(input state_t s, input logic [5:0] o);
      case (s)
         FETCH:   next_of = DECODE;
         DECODE:
            case (o)
               OP_LW, OP_SW: next_of = MEMADR;
               OP_R:         next_of = RTYPEEX;
               OP_BEQ:       next_of = BEQEX;
               OP_ADDI:      next_of = ADDIEX;
               OP_J:         next_of = JEX;
               default:      next_of = FETCH;
            endcase
         MEMADR:
            case (o)
               OP_LW:   next_of = MEMRD;
               OP_SW:   next_of = MEMWR;
               default: next_of = FETCH;
            endcase
         MEMRD:   next_of = MEMWB;
         RTYPEEX: next_of = RTYPEWB;
         ADDIEX:  next_of = ADDIWB;
         default: next_of = FETCH;
      endcase
   endfunction

   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_of = '0;
      case (s)
         FETCH:   begin ctrl_of.irwrite = 1'b1; ctrl_of.pcwrite = 1'b1; ctrl_of.alusrcb = 2'b01; end
         DECODE:  ctrl_of.alusrcb = 2'b11;
         MEMADR, ADDIEX: begin ctrl_of.alusrca = 1'b1; ctrl_of.alusrcb = 2'b10; end
         MEMRD:   ctrl_of.iord = 1'b1;
         MEMWR:   begin ctrl_of.iord = 1'b1; ctrl_of.memwrite = 1'b1; end
         MEMWB:   begin ctrl_of.regwrite = 1'b1; ctrl_of.memtoreg = 1'b1; end
         RTYPEEX: begin ctrl_of.alusrca = 1'b1; ctrl_of.aluop = 2'b10; end
         RTYPEWB: begin ctrl_of.regwrite = 1'b1; ctrl_of.regdst = 1'b1; end
         ADDIWB:  ctrl_of.regwrite = 1'b1;
         BEQEX:   begin
            ctrl_of.alusrca = 1'b1; ctrl_of.aluop = 2'b01;
            ctrl_of.pcsrc = 2'b01;  ctrl_of.branch = 1'b1;
         end
         JEX:     begin ctrl_of.pcsrc = 2'b10; ctrl_of.pcwrite = 1'b1; end
         default: ctrl_of = '0;
      endcase
   endfunction

   state_t st;
   ctrl_t  c;

   // Outputs are registered by decoding the state being entered, so they
   // stay pure functions of the current state without a decode stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st <= FETCH;
         c  <= ctrl_of(FETCH);
      end else begin
         st <= next_of(st, op);
         c  <= ctrl_of(next_of(st, op));
      end
   end

   always_comb begin
      alucontrol = 3'b010;
      case (c.aluop)
         2'b01: alucontrol = 3'b110;
         2'b10:
            case (funct)
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         default: alucontrol = 3'b010;
      endcase
   end

   assign pcen     = c.pcwrite | (c.branch & zero);
   assign memwrite = c.memwrite;
   assign irwrite  = c.irwrite;
   assign regwrite = c.regwrite;
   assign alusrca  = c.alusrca;
   assign iord     = c.iord;
   assign memtoreg = c.memtoreg;
   assign regdst   = c.regdst;
   assign alusrcb  = c.alusrcb;
   assign pcsrc    = c.pcsrc;
   assign state    = st;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and random
// instructions compared against a per-signal behavioural model.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;

   typedef int iq_t[$];

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
      .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
   );

   always #5 clk = ~clk;

   logic [14:0] obs;
   assign obs = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                 alusrcb, pcsrc, alucontrol};

   // Expected state walk of one instruction, starting at FETCH.
   function automatic iq_t exp_seq(input logic [5:0] o);
      case (o)
         6'b100011: return '{0, 1, 2, 3, 4};
         6'b101011: return '{0, 1, 2, 5};
         6'b000000: return '{0, 1, 6, 7};
         6'b000100: return '{0, 1, 8};
         6'b001000: return '{0, 1, 9, 11};
         6'b000010: return '{0, 1, 10};
         default:   return '{0, 1};
      endcase
   endfunction

   // Each control line described by the set of states in which it is high.
   function automatic logic [14:0] model(input int s, input logic [5:0] f, input logic z);
      logic [2:0] alu;
      logic [1:0] srcb, psrc;
      logic       pe;
      alu = 3'b010;
      if (s == 8) alu = 3'b110;
      if (s == 6) begin
         if (f == 6'b100010) alu = 3'b110;
         else if (f == 6'b100100) alu = 3'b000;
         else if (f == 6'b100101) alu = 3'b001;
         else if (f == 6'b101010) alu = 3'b111;
      end
      srcb = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s == 2 || s == 9) ? 2'b10 : 2'b00;
      psrc = (s == 8) ? 2'b01 : (s == 10) ? 2'b10 : 2'b00;
      pe   = (s == 0) || (s == 10) || (s == 8 && z);
      return {pe, s == 5, s == 0, (s == 4 || s == 7 || s == 11),
              (s == 2 || s == 6 || s == 8 || s == 9), (s == 3 || s == 5),
              s == 4, s == 7, srcb, psrc, alu};
   endfunction

   // Runs one instruction from FETCH back to FETCH; caller is #1 past an edge.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input string tag);
      iq_t seq;
      op = o; funct = f; zero = z;
      seq = exp_seq(o);
      foreach (seq[i]) begin
         checks++;
         if (state !== 4'(seq[i])) begin
            errors++;
            $display("FAIL %s step%0d state: got %0d want %0d", tag, i, state, seq[i]);
         end
         checks++;
         if (obs !== model(seq[i], f, z)) begin
            errors++;
            $display("FAIL %s step%0d outputs: got %b want %b", tag, i, obs, model(seq[i], f, z));
         end
         checks++;
         if (memwrite && regwrite) begin
            errors++;
            $display("FAIL %s step%0d write_overlap: got 1 want 0", tag, i);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (state !== 4'd0) begin
         errors++;
         $display("FAIL %s return_fetch: got %0d want 0", tag, state);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; op = 6'b100011; funct = '0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({state, irwrite, pcen} !== {4'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL reset_held: got st=%0d ir=%b pcen=%b want 0 1 1", state, irwrite, pcen);
      end
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if ({state, irwrite, pcen, memwrite, regwrite} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_cycle0: got st=%0d ir=%b pcen=%b want 0 1 1", state, irwrite, pcen);
      end
      run_instr(6'b100011, 6'h00, 1'b0, "lw_after_reset");
   endtask

   task automatic test_directed();
      run_instr(6'b100011, 6'h15, 1'b1, "lw");
      run_instr(6'b101011, 6'h00, 1'b0, "sw");
      run_instr(6'b000000, 6'b101010, 1'b0, "r_slt");
      run_instr(6'b000000, 6'b100000, 1'b0, "r_add");
      run_instr(6'b000000, 6'b100010, 1'b1, "r_sub");
      run_instr(6'b000000, 6'b100100, 1'b0, "r_and");
      run_instr(6'b000000, 6'b100101, 1'b0, "r_or");
      run_instr(6'b000000, 6'b111111, 1'b0, "r_other");
      run_instr(6'b000100, 6'h00, 1'b1, "beq_taken");
      run_instr(6'b000100, 6'h00, 1'b0, "beq_not_taken");
      run_instr(6'b001000, 6'h00, 1'b1, "addi");
      run_instr(6'b000010, 6'h00, 1'b0, "j");
      run_instr(6'b111111, 6'h00, 1'b1, "unknown_op");
   endtask

   task automatic test_memadr_other();
      op = 6'b100011;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (state !== 4'd2) begin
         errors++;
         $display("FAIL memadr_reach: got %0d want 2", state);
      end
      op = 6'b000001;
      @(posedge clk); #1;
      checks++;
      if (state !== 4'd0) begin
         errors++;
         $display("FAIL memadr_other_op: got %0d want 0", state);
      end
   endtask

   // Async reset in the middle of a write state must kill the write at once.
   task automatic test_abort(input logic [5:0] o, input int steps, input int wstate,
                             input string tag);
      op = o; funct = '0; zero = 1'b0;
      repeat (steps) begin @(posedge clk); #1; end
      checks++;
      if (state !== 4'(wstate) || (memwrite | regwrite) !== 1'b1) begin
         errors++;
         $display("FAIL %s pre_abort: got st=%0d mw=%b rw=%b want st=%0d write=1",
                  tag, state, memwrite, regwrite, wstate);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({state, memwrite, regwrite} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s abort: got st=%0d mw=%b rw=%b want 0 0 0", tag, state, memwrite, regwrite);
      end
      @(posedge clk); #1;
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if ({state, memwrite, regwrite} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s after_release: got st=%0d mw=%b rw=%b want 0 0 0", tag, state, memwrite, regwrite);
      end
      run_instr(6'b000010, 6'h00, 1'b0, "j_after_abort");
   endtask

   task automatic test_random();
      logic [5:0] ops [7];
      logic [5:0] functs [6];
      logic [5:0] o, f;
      ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
      functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      for (int n = 0; n < 60; n++) begin
         o = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
         run_instr(o, f, 1'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_memadr_other();
      test_abort(6'b101011, 3, 5, "abort_sw");
      test_abort(6'b100011, 4, 4, "abort_lw");
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
